// File: rtl/sar_pkg.sv
// rtl/sar_pkg.sv - shared types, defaults and width helpers for the SAR controller
package sar_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SAMPLE,
        COMP_HI,
        COMP_LO,
        DONE
    } sar_state_t;

    localparam int SAR_N_DEF          = 8;
    localparam int SAR_SAMPLE_CYC_DEF = 2;
    localparam int SAR_COMP_CYC_DEF   = 2;

    function automatic int cnt_width(input int sample_cyc, input int comp_cyc);
        int m;
        m = (sample_cyc > comp_cyc) ? sample_cyc : comp_cyc;
        return $clog2(m + 1);
    endfunction

    function automatic int idx_width(input int n);
        return $clog2(n);
    endfunction

    localparam int SAR_CNT_W = cnt_width(SAR_SAMPLE_CYC_DEF, SAR_COMP_CYC_DEF);
    localparam int SAR_IDX_W = idx_width(SAR_N_DEF);

endpackage

// File: rtl/sar_reg.sv
// rtl/sar_reg.sv - successive-approximation register: keeps/clears the trial bit and arms the next one
module sar_reg
    import sar_pkg::*;
#(
    parameter int N     = SAR_N_DEF,
    parameter int IDX_W = SAR_IDX_W
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             init,
    input  logic             decide,
    input  logic             d,
    input  logic [IDX_W-1:0] idx,
    output logic [N-1:0]     code
);

    logic [N-1:0] code_d;
    logic [N-1:0] code_q;

    always_comb begin
        code_d = code_q;
        if (init) begin
            code_d = {1'b1, {(N-1){1'b0}}};
        end else if (decide) begin
            code_d[idx] = d;
            if (idx != '0) begin
                code_d[idx - 1'b1] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            code_q <= '0;
        end else begin
            code_q <= code_d;
        end
    end

    assign code = code_q;

endmodule

// File: rtl/sar_ctrl.sv
// rtl/sar_ctrl.sv - SAR ADC conversion sequencer: sample/hold, comparator clocking, result capture
module sar_ctrl
    import sar_pkg::*;
#(
    parameter int N          = SAR_N_DEF,
    parameter int SAMPLE_CYC = SAR_SAMPLE_CYC_DEF,
    parameter int COMP_CYC   = SAR_COMP_CYC_DEF
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         start,
    input  logic         abort,
    input  logic         comp_dout,
    input  logic         comp_doutb,
    output logic         sample,
    output logic         comp_clk,
    output logic [N-1:0] dac_code,
    output logic [N-1:0] dout,
    output logic         done,
    output logic         busy,
    output logic         meta_err
);

    localparam int CNT_W = cnt_width(SAMPLE_CYC, COMP_CYC);
    localparam int IDX_W = idx_width(N);
    localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_CYC - 1);
    localparam logic [CNT_W-1:0] COMP_LAST   = CNT_W'(COMP_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_MSB     = IDX_W'(N - 1);

    sar_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             sample_q, sample_d;
    logic             comp_clk_q, comp_clk_d;
    logic [N-1:0]     dout_q, dout_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             meta_err_q, meta_err_d;

    logic             reg_init;
    logic             reg_decide;
    logic             reg_d;
    logic             tie;

    // Equal complementary outputs mean the sense amp did not regenerate; resolve as 1.
    assign tie   = (comp_dout == comp_doutb);
    assign reg_d = tie | comp_dout;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        sample_d   = sample_q;
        comp_clk_d = comp_clk_q;
        dout_d     = dout_q;
        done_d     = 1'b0;
        busy_d     = busy_q;
        meta_err_d = meta_err_q;
        reg_init   = 1'b0;
        reg_decide = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d    = SAMPLE;
                    busy_d     = 1'b1;
                    sample_d   = 1'b1;
                    meta_err_d = 1'b0;
                    idx_d      = IDX_MSB;
                    cnt_d      = '0;
                    reg_init   = 1'b1;
                end
            end
            SAMPLE: begin
                if (cnt_q == SAMPLE_LAST) begin
                    state_d    = COMP_HI;
                    sample_d   = 1'b0;
                    comp_clk_d = 1'b1;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            COMP_HI: begin
                if (cnt_q == COMP_LAST) begin
                    reg_decide = 1'b1;
                    comp_clk_d = 1'b0;
                    state_d    = COMP_LO;
                    cnt_d      = '0;
                    if (tie) begin
                        meta_err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            COMP_LO: begin
                if (idx_q != '0) begin
                    idx_d      = idx_q - 1'b1;
                    comp_clk_d = 1'b1;
                    state_d    = COMP_HI;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                dout_d  = dac_code;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort overrides whatever the active state decided; the DAC code simply freezes.
        if (abort && (state_q != IDLE)) begin
            state_d    = IDLE;
            sample_d   = 1'b0;
            comp_clk_d = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b0;
            dout_d     = dout_q;
            meta_err_d = meta_err_q;
            cnt_d      = '0;
            reg_decide = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= IDX_MSB;
            sample_q   <= 1'b0;
            comp_clk_q <= 1'b0;
            dout_q     <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            meta_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            sample_q   <= sample_d;
            comp_clk_q <= comp_clk_d;
            dout_q     <= dout_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            meta_err_q <= meta_err_d;
        end
    end

    sar_reg #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_sar_reg (
        .clk    (clk),
        .rstn   (rstn),
        .init   (reg_init),
        .decide (reg_decide),
        .d      (reg_d),
        .idx    (idx_q),
        .code   (dac_code)
    );

    assign sample   = sample_q;
    assign comp_clk = comp_clk_q;
    assign dout     = dout_q;
    assign done     = done_q;
    assign busy     = busy_q;
    assign meta_err = meta_err_q;

endmodule

// File: tb/tb_sar_ctrl.sv
// tb/tb_sar_ctrl.sv - self-checking bench for sar_ctrl with a behavioural binary-search model
module tb_sar_ctrl;

    logic       clk = 1'b0;
    logic       rstn;
    logic       start;
    logic       abort;
    logic       comp_dout;
    logic       comp_doutb;
    logic       sample;
    logic       comp_clk;
    logic [7:0] dac_code;
    logic [7:0] dout;
    logic       done;
    logic       busy;
    logic       meta_err;

    int vecs = 0;
    int errs = 0;

    logic [7:0] target    = 8'h00;
    logic [7:0] meta_mask = 8'h00;
    int         tie_mode  = 0;

    logic [7:0] cmp_lsb;
    logic       cmp_d;
    logic       cmp_meta;

    sar_ctrl #(.N(8), .SAMPLE_CYC(2), .COMP_CYC(2)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .abort      (abort),
        .comp_dout  (comp_dout),
        .comp_doutb (comp_doutb),
        .sample     (sample),
        .comp_clk   (comp_clk),
        .dac_code   (dac_code),
        .dout       (dout),
        .done       (done),
        .busy       (busy),
        .meta_err   (meta_err)
    );

    always #5 clk = ~clk;

    // Comparator environment: ideal compare against target, or tied; meta bits force both outputs low.
    always_comb begin
        cmp_lsb = dac_code & (~dac_code + 8'd1);
        if (tie_mode == 1)      cmp_d = 1'b1;
        else if (tie_mode == 2) cmp_d = 1'b0;
        else                    cmp_d = (dac_code <= target);
        cmp_meta   = |(cmp_lsb & meta_mask);
        comp_dout  = cmp_meta ? 1'b0 : cmp_d;
        comp_doutb = cmp_meta ? 1'b0 : ~cmp_d;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Binary search: each trial keeps its bit when the comparator says trial <= input.
    function automatic void ref_conv(input logic [7:0] tgt, input logic [7:0] mm, input int tie,
                                     output logic [7:0][7:0] trials, output logic [7:0] res);
        logic [7:0] code;
        logic [7:0] trial;
        bit         d;
        code = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            trial = code | (8'd1 << i);
            trials[7 - i] = trial;
            if (mm[i])         d = 1'b1;
            else if (tie == 1) d = 1'b1;
            else if (tie == 2) d = 1'b0;
            else               d = (trial <= tgt);
            if (d) code = trial;
        end
        res = code;
    endfunction

    task automatic convert(input logic [7:0] tgt, input logic [7:0] mm, input int tie,
                           input int start_at, input int abort_at,
                           input logic [7:0] exp_dout, input logic exp_meta);
        logic [7:0][7:0] trials;
        logic [7:0]      res;
        logic [7:0]      done_val;
        logic            prev_clk;
        int pulses, hi_run, lo_run, bad_shape, bad_trial, dones, done_cyc;

        ref_conv(tgt, mm, tie, trials, res);
        target = tgt; meta_mask = mm; tie_mode = tie;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk("busy_on_accept", busy, 1);
        chk("sample_on_accept", sample, 1);
        chk("dac_init", dac_code, 8'h80);
        chk("meta_cleared_on_start", meta_err, 0);

        prev_clk = 1'b0; pulses = 0; hi_run = 0; lo_run = 0;
        bad_shape = 0; bad_trial = 0; dones = 0; done_cyc = -1; done_val = 8'h00;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (cyc - 1 == start_at) start = 1'b1;
            if (cyc - 1 == abort_at) abort = 1'b1;
            @(posedge clk); #1;
            start = 1'b0; abort = 1'b0;
            if (abort_at >= 0 && cyc == abort_at + 1) begin
                chk("abort_busy", busy, 0);
                chk("abort_comp_clk", comp_clk, 0);
                chk("abort_sample", sample, 0);
                chk("abort_done", done, 0);
                chk("abort_dout_kept", dout, exp_dout);
                chk("abort_dac_held", dac_code, trials[5]);
                repeat (40) begin
                    @(posedge clk); #1;
                    if (done) dones++;
                end
                chk("abort_no_done", dones, 0);
                chk("abort_dac_still_held", dac_code, trials[5]);
                return;
            end
            if (comp_clk && !prev_clk) begin
                if (pulses > 0 && lo_run != 1) bad_shape++;
                if (pulses < 8 && dac_code !== trials[pulses]) bad_trial++;
                pulses++;
                hi_run = 0;
                lo_run = 0;
            end
            if (!comp_clk && prev_clk && hi_run != 2) bad_shape++;
            if (comp_clk) hi_run++;
            else if (pulses > 0 && pulses < 8) lo_run++;
            if (done) begin
                dones++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
                    done_val = dout;
                end
            end
            prev_clk = comp_clk;
        end
        chk("done_latency", done_cyc, 27);
        chk("done_count", dones, 1);
        chk("dout_expected", done_val, exp_dout);
        chk("dout_vs_model", done_val, res);
        chk("meta_err", meta_err, exp_meta);
        chk("comp_clk_pulses", pulses, 8);
        chk("comp_clk_shape", bad_shape, 0);
        chk("dac_trial_sequence", bad_trial, 0);
        chk("busy_after_done", busy, 0);
    endtask

    task automatic reset_mid();
        int dones;
        target = 8'hA5; meta_mask = 8'h00; tie_mode = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("comp_hi_before_reset", comp_clk, 1);
        rstn = 1'b0;
        #1;
        chk("async_reset_outputs", {sample, comp_clk, dac_code, dout, done, busy, meta_err}, 0);
        @(negedge clk);
        rstn = 1'b1;
        dones = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        chk("no_done_after_reset", dones, 0);
        chk("idle_after_reset", busy, 0);
    endtask

    typedef struct {
        logic [7:0] tgt;
        logic [7:0] mm;
        int         tie;
        int         start_at;
        int         abort_at;
        logic [7:0] exp_dout;
        logic       exp_meta;
    } vec_t;

    vec_t tbl[6];

    initial begin
        logic [7:0][7:0] rtr;
        logic [7:0]      rres;
        logic [7:0]      rtgt;
        logic [7:0]      rmm;

        tbl[0] = '{8'hA5, 8'h00, 0, -1, -1, 8'hA5, 1'b0};
        tbl[1] = '{8'h00, 8'h00, 1, -1, -1, 8'hFF, 1'b0};
        tbl[2] = '{8'hFF, 8'h00, 2, -1, -1, 8'h00, 1'b0};
        tbl[3] = '{8'hA1, 8'h04, 0, -1, -1, 8'hA4, 1'b1};
        tbl[4] = '{8'hA5, 8'h00, 0, 11, -1, 8'hA5, 1'b0};
        tbl[5] = '{8'hA5, 8'h00, 0, -1, 16, 8'hA5, 1'b0};

        rstn = 1'b0; start = 1'b0; abort = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {sample, comp_clk, dac_code, dout, done, busy, meta_err}, 0);
        rstn = 1'b1;

        abort = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0; start = 1'b0;
        chk("abort_beats_start_in_idle", busy, 0);

        for (int v = 0; v < 6; v++) begin
            convert(tbl[v].tgt, tbl[v].mm, tbl[v].tie, tbl[v].start_at, tbl[v].abort_at,
                    tbl[v].exp_dout, tbl[v].exp_meta);
        end

        for (int r = 0; r < 8; r++) begin
            rtgt = 8'($urandom_range(0, 255));
            rmm  = ($urandom_range(0, 2) == 0) ? (8'd1 << $urandom_range(0, 7)) : 8'h00;
            ref_conv(rtgt, rmm, 0, rtr, rres);
            convert(rtgt, rmm, 0, -1, -1, rres, (rmm != 8'h00));
        end

        reset_mid();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/sar_ctrl.md
Name: sar_ctrl

Overview:
- Synchronous successive-approximation controller for the SAR ADC example.
- Sequences the sample/hold switch and drives the clock of the clocked sense-amp comparator.
- Each cycle it reads the differential comparator decision and updates the binary-weighted DAC code.
- Delivers one N-bit result per start request with a done pulse; all timing is counted in system-clock cycles.

Parameters:
- N, 8, conversion resolution in bits (N >= 2).
- SAMPLE_CYC, 2, cycles the sample switch is held closed (>= 1).
- COMP_CYC, 2, cycles comp_clk stays high per bit: regeneration window (>= 1).

Ports:
- clk  in  1  system clock, rising-edge active.
- rstn  in  1  asynchronous active-low reset.
- start  in  1  conversion request, sampled only in IDLE.
- abort  in  1  synchronous abort; returns to IDLE next cycle, no done.
- comp_dout  in  1  comparator output (1: vinp-vinn > 0).
- comp_doutb  in  1  comparator complementary output.
- sample  out  1  sample/hold switch enable.
- comp_clk  out  1  comparator clock (rising edge = sample, low = reset).
- dac_code  out  N  code driven to the capacitive DAC.
- dout  out  N  last completed conversion result, held until next done.
- done  out  1  one-cycle pulse when dout is updated.
- busy  out  1  high from SAMPLE entry until return to IDLE.
- meta_err  out  1  sticky; set if comp_dout==comp_doutb at any decision point; cleared by the next accepted start.

Behaviour:
- Reset (rstn=0, asynchronous) forces all of the following: state=IDLE, sample=0, comp_clk=0, dac_code=0, dout=0, done=0, busy=0, meta_err=0, bit index=N-1.
- All outputs are registered. A reset mid-conversion discards the partial result; dout also clears.
- States: IDLE, SAMPLE, COMP_HI, COMP_LO, DONE.
- IDLE:
  - On start=1, go to SAMPLE next cycle.
  - Set busy=1, sample=1, dac_code=1<<(N-1), meta_err=0, bit index i=N-1.
- SAMPLE:
  - Hold for SAMPLE_CYC cycles, then go to COMP_HI.
  - sample=0 and comp_clk=1 in the same cycle.
- COMP_HI:
  - comp_clk=1 for COMP_CYC cycles.
  - On the last cycle, evaluate the decision d=comp_dout.
  - dac_code[i] is cleared if d=0 and kept if d=1.
  - If i>0, bit i-1 is also set.
  - If comp_dout==comp_doutb, treat d as 1 and set meta_err.
  - Go to COMP_LO.
- COMP_LO:
  - comp_clk=0 for exactly one cycle (comparator reset phase).
  - If i>0: decrement i and go to COMP_HI.
  - If i==0: go to DONE.
- DONE (one cycle):
  - dout<=dac_code, done=1, busy=0, dac_code held.
  - Go to IDLE next cycle.
- Latency: start accepted at edge 0 → done high for the cycle after edge SAMPLE_CYC + N*(COMP_CYC+1) + 1. With defaults this is 2+8*3+1 = 27 cycles.
- start while busy: ignored, with no queueing. start asserted in the DONE cycle is ignored; it must be held or re-asserted in IDLE.
- abort:
  - Has priority over all transitions in every non-IDLE state.
  - Next cycle: state=IDLE, sample=0, comp_clk=0, busy=0, no done.
  - dout is unchanged and dac_code is held.
  - abort in IDLE has no effect. abort and start together in IDLE: abort wins and start is ignored.
- comp_clk glitch-free: it is the output of a single flop only.

Decomposition:
- Shared package sar_pkg holds:
  - the state enum sar_state_t (IDLE, SAMPLE, COMP_HI, COMP_LO, DONE);
  - localparam widths for the cycle counters, $clog2 of max(SAMPLE_CYC, COMP_CYC)+1;
  - bit index width $clog2(N).
- One sub-module, sar_reg:
  - the N-bit successive-approximation register, with inputs init, decide, d, idx;
  - it performs the keep/clear of the current bit and the set of the next bit.
- The FSM, counters and the meta_err check stay in sar_ctrl.

Test Plan:
- Reset mid-COMP_HI with N=8: assert rstn=0 → all outputs 0 immediately (asynchronous); after release, no done until a new start.
- Comparator model returns the decision for target code 8'hA5 (d = dac_code<=0xA5) → dac_code sequence 80,C0,A0,B0,A8,A4,A6,A5. done at cycle 27 with dout=8'hA5, meta_err=0.
- Extreme inputs, comparator tied to d=1 and to d=0 → dout=8'hFF and 8'h00 respectively. comp_clk shows exactly 8 high pulses of 2 cycles, each separated by a 1-cycle low.
- start pulsed during bit 4 of an active conversion → ignored; a single done at cycle 27 with the correct result.
- abort asserted in COMP_LO of bit 3 → next cycle busy=0, comp_clk=0, no done, dout keeps the previous result (0xA5).
- comp_dout=comp_doutb=0 forced at the bit-2 decision → bit 2 resolved as 1, meta_err=1 after done. meta_err clears on the next accepted start.
